// File: rtl/uart_tx_slave.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_slave
//  Description : Wishbone classic slave feeding an 8N1 serial transmitter.
//                CPU writes to DATA are queued in a small FIFO and shifted
//                out LSB first; STATUS exposes FIFO and serialiser state.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_slave #(
    parameter logic [31:0] BASE_ADDRESS = 32'h4000_0000,
    parameter int          CLK_DIV      = 16,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stb_i,
    input  logic        cyc_i,
    input  logic [31:0] adr_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] dat_i,
    output logic [31:0] dat_o,
    input  logic        we_i,
    output logic        ack_o,
    output logic        err_o,
    output logic        rty_o,
    output logic        tx_o,
    output logic        irq_o
);

    localparam int c_PW = $clog2(FIFO_DEPTH);
    localparam int c_CW = c_PW + 1;
    localparam int c_BW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [c_PW-1:0] r_wr_ptr, r_rd_ptr;
    logic [c_CW-1:0] r_count;
    state_t          r_state, w_state_nxt;
    logic [c_BW-1:0] r_baud, w_baud_nxt;
    logic [2:0]      r_bit, w_bit_nxt;
    logic [7:0]      r_shift, w_shift_nxt;
    logic            r_ack, r_err, r_irq;
    logic [31:0]     r_dat;

    logic            w_hit, w_push, w_pop, w_full, w_full_eff, w_empty, w_busy;
    logic            w_ack_d, w_err_d, w_tx, w_baud_end;
    logic [31:0]     w_rdat_d, w_status, w_cnt32;
    logic [3:0]      w_cnt_sat;
    logic            w_unused_bits;

    assign w_unused_bits = ^{dat_i[31:8], sel_i[3:1]};

    // A response cycle blocks re-sampling so one bus access yields one effect
    assign w_hit = cyc_i & stb_i & (adr_i[31:4] == BASE_ADDRESS[31:4]) & ~(r_ack | r_err);

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == c_CW'(FIFO_DEPTH));
    assign w_busy     = (r_state != S_IDLE);
    assign w_pop      = (r_state == S_IDLE) && !w_empty;
    // A pop in the same cycle frees a slot for the incoming byte
    assign w_full_eff = w_full && !w_pop;
    assign w_baud_end = (r_baud == c_BW'(CLK_DIV - 1));

    assign w_cnt32   = 32'(r_count);
    assign w_cnt_sat = (w_cnt32 > 32'd15) ? 4'hF : w_cnt32[3:0];
    assign w_status  = {24'h0, w_cnt_sat, 1'b0, w_busy, w_empty, w_full};

    // Register decode and the response to be presented next cycle
    always_comb begin
        w_push   = 1'b0;
        w_ack_d  = 1'b0;
        w_err_d  = 1'b0;
        w_rdat_d = 32'h0;
        if (w_hit) begin
            case (adr_i[3:0])
                4'h0: begin
                    if (we_i && sel_i[0]) begin
                        if (w_full_eff) begin
                            w_err_d = 1'b1;
                        end else begin
                            w_push  = 1'b1;
                            w_ack_d = 1'b1;
                        end
                    end else begin
                        w_ack_d = 1'b1;
                    end
                end
                4'h4: begin
                    w_ack_d = 1'b1;
                    if (!we_i) begin
                        w_rdat_d = w_status;
                    end
                end
                default: w_err_d = 1'b1;
            endcase
        end
    end

    // Registered bus response and interrupt
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            r_dat <= 32'h0;
            r_irq <= 1'b1;
        end else begin
            r_ack <= w_ack_d;
            r_err <= w_err_d;
            r_dat <= w_rdat_d;
            r_irq <= w_empty & ~w_busy;
        end
    end

    // FIFO storage needs no reset; validity is tracked by the pointers
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= dat_i[7:0];
        end
    end

    // FIFO pointers and occupancy; power-of-two depth gives natural wrap
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Serialiser state register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_baud  <= w_baud_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
        end
    end

    // Serialiser next state and line level
    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_tx        = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_shift_nxt = r_mem[r_rd_ptr];
                    w_baud_nxt  = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                w_tx = 1'b0;
                if (w_baud_end) begin
                    w_baud_nxt  = '0;
                    w_state_nxt = S_DATA;
                end else begin
                    w_baud_nxt = r_baud + c_BW'(1);
                end
            end
            S_DATA: begin
                w_tx = r_shift[0];
                if (w_baud_end) begin
                    w_baud_nxt  = '0;
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    if (r_bit == 3'd7) begin
                        w_bit_nxt   = '0;
                        w_state_nxt = S_STOP;
                    end else begin
                        w_bit_nxt = r_bit + 3'd1;
                    end
                end else begin
                    w_baud_nxt = r_baud + c_BW'(1);
                end
            end
            S_STOP: begin
                if (w_baud_end) begin
                    w_baud_nxt  = '0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_baud_nxt = r_baud + c_BW'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign dat_o = r_dat;
    assign ack_o = r_ack;
    assign err_o = r_err;
    assign rty_o = 1'b0;
    assign tx_o  = w_tx;
    assign irq_o = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_slave
//  Description : Directed self-checking bench for uart_tx_slave.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_slave;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        stb_i, cyc_i, we_i;
    logic [31:0] adr_i, dat_i;
    logic [3:0]  sel_i;
    logic [31:0] dat_o;
    logic        ack_o, err_o, rty_o, tx_o, irq_o;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    logic        r_ack, r_err, r_late;
    logic [31:0] r_rd;
    logic [7:0]  r_byte;
    logic        r_exp;

    localparam logic [31:0] c_DATA   = 32'h4000_0000;
    localparam logic [31:0] c_STATUS = 32'h4000_0004;

    always #5 clk_i = ~clk_i;

    uart_tx_slave dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .stb_i (stb_i),
        .cyc_i (cyc_i),
        .adr_i (adr_i),
        .sel_i (sel_i),
        .dat_i (dat_i),
        .dat_o (dat_o),
        .we_i  (we_i),
        .ack_o (ack_o),
        .err_o (err_o),
        .rty_o (rty_o),
        .tx_o  (tx_o),
        .irq_o (irq_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One bus access; called 1 time unit after a rising edge, returns likewise
    task automatic wb(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                      input logic [31:0] dat, output logic ack, output logic err,
                      output logic [31:0] rd, output logic late);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = we; adr_i = adr; sel_i = sel; dat_i = dat;
        @(posedge clk_i); #1;
        ack = ack_o; err = err_o; rd = dat_o;
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; adr_i = '0; sel_i = '0; dat_i = '0;
        @(posedge clk_i); #1;
        late = ack_o | err_o;
    endtask

    initial begin
        rst_i = 1'b0; stb_i = 1'b0; cyc_i = 1'b0; we_i = 1'b0;
        adr_i = '0; dat_i = '0; sel_i = '0;
        #12;
        chk("rst_tx",  32'(tx_o),  32'h1);
        chk("rst_ack", 32'(ack_o), 32'h0);
        chk("rst_err", 32'(err_o), 32'h0);
        chk("rst_irq", 32'(irq_o), 32'h1);
        chk("rst_dat", dat_o,      32'h0);
        chk("rty",     32'(rty_o), 32'h0);
        @(posedge clk_i); #1;
        rst_i = 1'b1;

        // Reset mid-frame with bytes still queued
        wb(1'b1, c_DATA, 4'hF, 32'hAA, r_ack, r_err, r_rd, r_late);
        wb(1'b1, c_DATA, 4'hF, 32'hBB, r_ack, r_err, r_rd, r_late);
        repeat (3) @(posedge clk_i);
        #1;
        chk("midframe_tx_low", 32'(tx_o), 32'h0);
        #3 rst_i = 1'b0;
        #1;
        chk("async_rst_tx",  32'(tx_o),  32'h1);
        chk("async_rst_ack", 32'(ack_o), 32'h0);
        chk("async_rst_irq", 32'(irq_o), 32'h1);
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        wb(1'b0, c_STATUS, 4'hF, 32'h0, r_ack, r_err, r_rd, r_late);
        chk("post_rst_status", r_rd, 32'h2);
        chk("post_rst_status_ack", 32'(r_ack), 32'h1);

        // Single frame of 'h55
        wb(1'b1, c_DATA, 4'h1, 32'h55, r_ack, r_err, r_rd, r_late);
        chk("w55_ack",      32'(r_ack),  32'h1);
        chk("w55_err",      32'(r_err),  32'h0);
        chk("w55_ack_once", 32'(r_late), 32'h0);
        chk("frame_irq_low", 32'(irq_o), 32'h0);
        r_byte = 8'h55;
        for (int i = 0; i < 160; i++) begin
            if (i < 16)       r_exp = 1'b0;
            else if (i < 144) r_exp = r_byte[(i - 16) / 16];
            else              r_exp = 1'b1;
            chk($sformatf("frame55_tx_c%0d", i), 32'(tx_o), 32'(r_exp));
            @(posedge clk_i); #1;
        end
        chk("idle_tx",        32'(tx_o),  32'h1);
        chk("irq_lag",        32'(irq_o), 32'h0);
        @(posedge clk_i); #1;
        chk("irq_back",       32'(irq_o), 32'h1);

        // Fill: first byte goes to the serialiser, eight fill the FIFO
        for (int k = 0; k < 9; k++) begin
            wb(1'b1, c_DATA, 4'h1, 32'(k + 1), r_ack, r_err, r_rd, r_late);
            chk($sformatf("fill_ack_%0d", k), 32'(r_ack), 32'h1);
        end
        wb(1'b1, c_DATA, 4'h1, 32'hEE, r_ack, r_err, r_rd, r_late);
        chk("full_err", 32'(r_err), 32'h1);
        chk("full_ack", 32'(r_ack), 32'h0);
        wb(1'b0, c_STATUS, 4'hF, 32'h0, r_ack, r_err, r_rd, r_late);
        chk("full_status", r_rd, 32'h85);

        // Unmapped offset inside the window
        wb(1'b0, 32'h4000_0008, 4'hF, 32'h0, r_ack, r_err, r_rd, r_late);
        chk("bad_off_err", 32'(r_err), 32'h1);
        chk("bad_off_ack", 32'(r_ack), 32'h0);
        chk("bad_off_dat", r_rd,       32'h0);
        chk("bad_off_once", 32'(r_late), 32'h0);
        wb(1'b0, c_STATUS, 4'hF, 32'h0, r_ack, r_err, r_rd, r_late);
        chk("bad_off_status", r_rd, 32'h85);

        // Clear out the queue
        #3 rst_i = 1'b0;
        @(posedge clk_i); #1;
        rst_i = 1'b1;

        // Byte lane 0 not selected: acknowledged, nothing queued
        wb(1'b1, c_DATA, 4'b1110, 32'h5A, r_ack, r_err, r_rd, r_late);
        chk("nosel_ack", 32'(r_ack), 32'h1);
        chk("nosel_err", 32'(r_err), 32'h0);
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("nosel_tx_c%0d", i), 32'(tx_o), 32'h1);
            @(posedge clk_i); #1;
        end
        wb(1'b0, c_STATUS, 4'hF, 32'h0, r_ack, r_err, r_rd, r_late);
        chk("nosel_status", r_rd, 32'h2);

        // DATA reads as zero, STATUS write is acknowledged
        wb(1'b0, c_DATA, 4'hF, 32'h0, r_ack, r_err, r_rd, r_late);
        chk("data_rd_ack", 32'(r_ack), 32'h1);
        chk("data_rd_dat", r_rd,       32'h0);
        wb(1'b1, c_STATUS, 4'hF, 32'hFF, r_ack, r_err, r_rd, r_late);
        chk("status_wr_ack", 32'(r_ack), 32'h1);

        // Outside the window: silence
        wb(1'b1, 32'h4000_0010, 4'hF, 32'h77, r_ack, r_err, r_rd, r_late);
        chk("miss_w_ack", 32'(r_ack), 32'h0);
        chk("miss_w_err", 32'(r_err), 32'h0);
        wb(1'b0, 32'h5000_0004, 4'hF, 32'h0, r_ack, r_err, r_rd, r_late);
        chk("miss_r_ack", 32'(r_ack), 32'h0);
        chk("miss_r_err", 32'(r_err), 32'h0);
        chk("miss_r_dat", r_rd,       32'h0);
        wb(1'b0, c_STATUS, 4'hF, 32'h0, r_ack, r_err, r_rd, r_late);
        chk("miss_status", r_rd, 32'h2);
        chk("miss_tx", 32'(tx_o), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
